// File: rtl/decode_pipe_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_pipe_stage_if
// Description : Bundle of the decode stage signals: the IF/ID input handshake
//               with its payload, the writeback port, the flush, and the
//               ID/EX output handshake with its registered payload.
//               master = upstream/downstream environment, slave = the stage.
//               Optional macro DECODE_PERF_EN adds the stall_cnt and
//               bubble_cnt observation counters.
// Ports       : in_valid/in_ready/in_pc/in_instr/in_imm/in_ctrl,
//               wb_we/wb_addr/wb_data, flush,
//               out_valid/out_ready/out_pc/out_rs1_data/out_rs2_data/out_imm,
//               out_rs1_addr/out_rs2_addr/out_rd_addr/out_funct3/out_funct7/
//               out_ctrl [, stall_cnt, bubble_cnt]
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_pipe_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
);
    // IF/ID side
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_imm;
    logic [CTRL_W-1:0] in_ctrl;

    // Writeback port
    logic              wb_we;
    logic [4:0]        wb_addr;
    logic [XLEN-1:0]   wb_data;

    logic              flush;

    // ID/EX side
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_rs1_data;
    logic [XLEN-1:0]   out_rs2_data;
    logic [XLEN-1:0]   out_imm;
    logic [4:0]        out_rs1_addr;
    logic [4:0]        out_rs2_addr;
    logic [4:0]        out_rd_addr;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [CTRL_W-1:0] out_ctrl;

`ifdef DECODE_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
`endif

    modport master (
        output in_valid, in_pc, in_instr, in_imm, in_ctrl,
        output wb_we, wb_addr, wb_data, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data,
        input  out_imm, out_rs1_addr, out_rs2_addr, out_rd_addr,
        input  out_funct3, out_funct7, out_ctrl
`ifdef DECODE_PERF_EN
        , input stall_cnt, bubble_cnt
`endif
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_imm, in_ctrl,
        input  wb_we, wb_addr, wb_data, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data,
        output out_imm, out_rs1_addr, out_rs2_addr, out_rd_addr,
        output out_funct3, out_funct7, out_ctrl
`ifdef DECODE_PERF_EN
        , output stall_cnt, bubble_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/decode_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_pipe_stage
// Description : Decode stage between IF/ID and EX. Holds the register file
//               (with same-cycle writeback bypass), detects load-use hazards
//               and inserts one bubble, and drives a valid/ready ID/EX
//               pipeline register with flush. While the payload is held by
//               backpressure, its operand data is refreshed from writeback.
//               Optional macro DECODE_PERF_EN adds saturating stall/bubble
//               counters on the interface.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous reset, active low
//               bus  - decode_pipe_stage_if.slave (IF/ID, WB, flush, ID/EX)
// Revision    : 1.0 - initial release
// ============================================================================
module decode_pipe_stage #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int CTRL_W    = 16,
    parameter int MEMRD_BIT = 0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    decode_pipe_stage_if.slave bus
);
    // Register index width: the low bits of each 5-bit register field.
    localparam int c_AW = $clog2(NREG);

    generate
        if ((NREG != 16) && (NREG != 32)) begin : g_bad_nreg
            $error("decode_pipe_stage: NREG must be 16 or 32");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [c_AW-1:0] w_rs1_idx;
    logic [c_AW-1:0] w_rs2_idx;
    logic [c_AW-1:0] w_wb_idx;
    logic            w_wb_wr;

    assign w_rs1_idx = bus.in_instr[15 +: c_AW];
    assign w_rs2_idx = bus.in_instr[20 +: c_AW];
    assign w_wb_idx  = bus.wb_addr[c_AW-1:0];
    // Index 0 is x0: never written, even when a 16-entry file aliases x16.
    assign w_wb_wr   = bus.wb_we && (w_wb_idx != '0);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_rf [NREG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wb_wr) begin
            r_rf[w_wb_idx] <= bus.wb_data;
        end
    end

    // Combinational reads with write-through bypass of the current writeback.
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    always_comb begin
        w_rs1_data = '0;
        if (w_rs1_idx != '0) begin
            if (w_wb_wr && (w_wb_idx == w_rs1_idx)) begin
                w_rs1_data = bus.wb_data;
            end else begin
                w_rs1_data = r_rf[w_rs1_idx];
            end
        end
    end

    always_comb begin
        w_rs2_data = '0;
        if (w_rs2_idx != '0) begin
            if (w_wb_wr && (w_wb_idx == w_rs2_idx)) begin
                w_rs2_data = bus.wb_data;
            end else begin
                w_rs2_data = r_rf[w_rs2_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // ID/EX register state
    // ------------------------------------------------------------------
    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rs1_addr;
    logic [4:0]        r_rs2_addr;
    logic [4:0]        r_rd_addr;
    logic [2:0]        r_funct3;
    logic [6:0]        r_funct7;
    logic [CTRL_W-1:0] r_ctrl;

    // ------------------------------------------------------------------
    // Handshake and hazard
    // ------------------------------------------------------------------
    logic            w_load_en;
    logic            w_hazard;
    logic            w_in_ready;
    logic [c_AW-1:0] w_rd_idx;
    logic            w_rs1_refresh;
    logic            w_rs2_refresh;

    assign w_rd_idx  = r_rd_addr[c_AW-1:0];
    assign w_load_en = !r_valid || bus.out_ready;

    // A load sitting in ID/EX whose destination is a source of the incoming
    // instruction: its data is not available until one cycle later.
    assign w_hazard  = r_valid && r_ctrl[MEMRD_BIT] && (w_rd_idx != '0) && bus.in_valid
                       && ((w_rd_idx == w_rs1_idx) || (w_rd_idx == w_rs2_idx));

    assign w_in_ready = w_load_en && !w_hazard && !bus.flush;

    // Held operands track writebacks so EX never consumes stale data.
    assign w_rs1_refresh = w_wb_wr && (w_wb_idx == r_rs1_addr[c_AW-1:0]);
    assign w_rs2_refresh = w_wb_wr && (w_wb_idx == r_rs2_addr[c_AW-1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
            r_funct3   <= '0;
            r_funct7   <= '0;
            r_ctrl     <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (w_load_en) begin
            if (w_hazard || !bus.in_valid) begin
                // Bubble (hazard) or empty slot: ctrl is kept zero while invalid.
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end else begin
                r_valid    <= 1'b1;
                r_pc       <= bus.in_pc;
                r_rs1_data <= w_rs1_data;
                r_rs2_data <= w_rs2_data;
                r_imm      <= bus.in_imm;
                r_rs1_addr <= bus.in_instr[19:15];
                r_rs2_addr <= bus.in_instr[24:20];
                r_rd_addr  <= bus.in_instr[11:7];
                r_funct3   <= bus.in_instr[14:12];
                r_funct7   <= bus.in_instr[31:25];
                r_ctrl     <= bus.in_ctrl;
            end
        end else begin
            if (w_rs1_refresh) begin
                r_rs1_data <= bus.wb_data;
            end
            if (w_rs2_refresh) begin
                r_rs2_data <= bus.wb_data;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_valid;
    assign bus.out_pc       = r_pc;
    assign bus.out_rs1_data = r_rs1_data;
    assign bus.out_rs2_data = r_rs2_data;
    assign bus.out_imm      = r_imm;
    assign bus.out_rs1_addr = r_rs1_addr;
    assign bus.out_rs2_addr = r_rs2_addr;
    assign bus.out_rd_addr  = r_rd_addr;
    assign bus.out_funct3   = r_funct3;
    assign bus.out_funct7   = r_funct7;
    assign bus.out_ctrl     = r_ctrl;

    // Opcode bits and (for a 16-entry file) the top address bit are not decoded here.
    wire logic w_unused = &{1'b0, bus.in_instr[6:0], bus.wb_addr};

`ifdef DECODE_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters (flush does not clear them)
    // ------------------------------------------------------------------
    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (bus.in_valid && !w_in_ready && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!bus.flush && w_load_en && w_hazard && (r_bubble_cnt != c_CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_pipe_stage
// Description : Scoreboard bench for decode_pipe_stage. A reference model of
//               the register file and ID/EX slot predicts in_ready, out_valid
//               and the captured payload; expected payloads are queued at the
//               input handshake and compared when EX accepts them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_pipe_stage;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [15:0] ctrl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_pipe_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

    decode_pipe_stage #(
        .XLEN(XLEN), .NREG(32), .CTRL_W(CTRL_W), .MEMRD_BIT(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_rf [32];
    bit          m_valid;
    logic [4:0]  m_rd;
    bit          m_memrd;
    bit          m_acc;
    exp_t        q[$];
    longint      m_stall;
    longint      m_bubble;
    int          n_rdy_seen;
    logic [31:0] pc_ctr = 32'h0000_1000;

    function automatic logic [31:0] enc(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3,
                                        input logic [6:0] f7);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [15:0] alu_ctrl();
        return (16'($urandom) & 16'hFFFE) | 16'h8000;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.wb_we && bus.wb_addr == a) return bus.wb_data;
        return m_rf[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_valid  = 0;
        m_rd     = 0;
        m_memrd  = 0;
        q.delete();
        m_stall  = 0;
        m_bubble = 0;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.in_imm    = '0;
        bus.in_ctrl   = '0;
        bus.wb_we     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    // One clock cycle: inputs are already driven (at the falling edge).
    task automatic step();
        logic [4:0] rs1, rs2;
        bit   le, hz, rdy;
        exp_t e, a;
        #1;
        rs1 = bus.in_instr[19:15];
        rs2 = bus.in_instr[24:20];
        n_cmp++;
        if (bus.out_valid !== m_valid) begin
            n_bad++;
            $display("FAIL out_valid: got %b expected %b at %0t", bus.out_valid, m_valid, $time);
        end
        if (!m_valid) begin
            n_cmp++;
            if (bus.out_ctrl !== '0) begin
                n_bad++;
                $display("FAIL out_ctrl_idle: got %h expected 0 at %0t", bus.out_ctrl, $time);
            end
        end
        le  = !m_valid || bus.out_ready;
        hz  = m_valid && m_memrd && (m_rd != 0) && bus.in_valid && ((m_rd == rs1) || (m_rd == rs2));
        rdy = le && !hz && !bus.flush;
        n_cmp++;
        if (bus.in_ready !== rdy) begin
            n_bad++;
            $display("FAIL in_ready: got %b expected %b at %0t", bus.in_ready, rdy, $time);
        end
        if (bus.in_valid && bus.in_ready === 1'b1) n_rdy_seen++;
        if (m_valid) begin
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard: model slot valid but queue empty at %0t", $time);
            end else if (bus.out_ready) begin
                e = q.pop_front();
                a = '{bus.out_pc, bus.out_rs1_data, bus.out_rs2_data, bus.out_imm,
                      bus.out_rs1_addr, bus.out_rs2_addr, bus.out_rd_addr,
                      bus.out_funct3, bus.out_funct7, bus.out_ctrl};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL payload: got %h expected %h at %0t", a, e, $time);
                end
            end else if (bus.flush) begin
                void'(q.pop_front());
            end else begin
                e = q[0];
                if (bus.wb_we && bus.wb_addr != 0 && bus.wb_addr == e.rs1a) e.rs1d = bus.wb_data;
                if (bus.wb_we && bus.wb_addr != 0 && bus.wb_addr == e.rs2a) e.rs2d = bus.wb_data;
                q[0] = e;
            end
        end
        m_acc = rdy && bus.in_valid;
        if (m_acc) begin
            e = '{bus.in_pc, m_read(rs1), m_read(rs2), bus.in_imm, rs1, rs2,
                  bus.in_instr[11:7], bus.in_instr[14:12], bus.in_instr[31:25], bus.in_ctrl};
            q.push_back(e);
        end
        if (bus.in_valid && !rdy) m_stall++;
        if (!bus.flush && le && hz) m_bubble++;
        if (bus.wb_we && bus.wb_addr != 0) m_rf[bus.wb_addr] = bus.wb_data;
        if (bus.flush) m_valid = 0;
        else if (le) begin
            if (hz || !bus.in_valid) m_valid = 0;
            else begin
                m_valid = 1;
                m_rd    = bus.in_instr[11:7];
                m_memrd = bus.in_ctrl[0];
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present an instruction until accepted; returns the cycles it took.
    task automatic issue(input logic [31:0] instr, input logic [15:0] ctrl, output int cycles);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_ctrl  = ctrl;
        bus.in_pc    = pc_ctr;
        bus.in_imm   = $urandom;
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!m_acc && cycles < 16);
        if (!m_acc) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout: got no handshake expected one within 16 cycles");
        end
        bus.in_valid = 1'b0;
        pc_ctr += 32'd4;
    endtask

    task automatic check_zero(input string tag);
        n_cmp++;
        if ({bus.out_valid, bus.out_pc, bus.out_rs1_data, bus.out_rs2_data, bus.out_imm,
             bus.out_rs1_addr, bus.out_rs2_addr, bus.out_rd_addr, bus.out_funct3,
             bus.out_funct7, bus.out_ctrl} !== '0) begin
            n_bad++;
            $display("FAIL %s: got valid=%b pc=%h rs1=%h rs2=%h ctrl=%h expected all zero",
                     tag, bus.out_valid, bus.out_pc, bus.out_rs1_data, bus.out_rs2_data, bus.out_ctrl);
        end
    endtask

    task automatic test_reset();
        int c;
        rst = 1'b0;
        idle();
        model_clear();
        @(negedge clk);
        check_zero("reset_initial");
        rst = 1'b1;
        // Some traffic, then reset while a payload is valid
        bus.wb_we = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'h0000_0055;
        issue(enc(5'd8, 5'd5, 5'd5, 3'd1, 7'd0), alu_ctrl(), c);
        bus.wb_we = 0;
        issue(enc(5'd9, 5'd5, 5'd2, 3'd2, 7'd3), alu_ctrl(), c);
        #2 rst = 1'b0;
        #1 check_zero("reset_midstream");
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        // RF must read zero after reset
        issue(enc(5'd10, 5'd5, 5'd5, 3'd0, 7'd0), alu_ctrl(), c);
        n_cmp++;
        if (bus.out_rs1_data !== 32'd0 || bus.out_rs2_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_rf_read: got %h/%h expected 0/0", bus.out_rs1_data, bus.out_rs2_data);
        end
        step();
    endtask

    task automatic test_stream();
        int c, base;
        idle();
        bus.wb_we = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'h0000_1234;
        step();
        bus.wb_we = 0;
        issue(enc(5'd6, 5'd5, 5'd5, 3'd0, 7'd0), alu_ctrl(), c);
        n_cmp++;
        if (bus.out_rs1_data !== 32'h1234 || bus.out_rs2_data !== 32'h1234 || bus.out_rd_addr !== 5'd6) begin
            n_bad++;
            $display("FAIL stream_add: got rs1=%h rs2=%h rd=%0d expected 1234/1234/6",
                     bus.out_rs1_data, bus.out_rs2_data, bus.out_rd_addr);
        end
        base = n_rdy_seen;
        for (int i = 0; i < 4; i++) begin
            issue(enc(5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), 3'($urandom), 7'($urandom)), alu_ctrl(), c);
        end
        n_cmp++;
        if (n_rdy_seen - base !== 4) begin
            n_bad++;
            $display("FAIL stream_throughput: got %0d ready cycles expected 4", n_rdy_seen - base);
        end
        step();
    endtask

    task automatic test_bypass();
        int c;
        idle();
        bus.wb_we = 1; bus.wb_addr = 5'd7; bus.wb_data = 32'h0000_CAFE;
        issue(enc(5'd10, 5'd7, 5'd0, 3'd0, 7'd0), alu_ctrl(), c);
        n_cmp++;
        if (bus.out_rs1_data !== 32'hCAFE || bus.out_rs2_data !== 32'd0) begin
            n_bad++;
            $display("FAIL bypass_x7: got %h/%h expected cafe/0", bus.out_rs1_data, bus.out_rs2_data);
        end
        bus.wb_addr = 5'd0; bus.wb_data = 32'hDEAD_0000;
        issue(enc(5'd11, 5'd0, 5'd7, 3'd0, 7'd0), alu_ctrl(), c);
        bus.wb_we = 0;
        n_cmp++;
        if (bus.out_rs1_data !== 32'd0 || bus.out_rs2_data !== 32'hCAFE) begin
            n_bad++;
            $display("FAIL bypass_x0: got %h/%h expected 0/cafe", bus.out_rs1_data, bus.out_rs2_data);
        end
        step();
    endtask

    task automatic test_load_use();
        int c;
        idle();
        issue(enc(5'd3, 5'd2, 5'd0, 3'd2, 7'd0), alu_ctrl() | 16'h0001, c);
        issue(enc(5'd4, 5'd3, 5'd1, 3'd0, 7'd0), alu_ctrl(), c);
        n_cmp++;
        if (c !== 2) begin
            n_bad++;
            $display("FAIL load_use_stall: got %0d cycles expected 2", c);
        end
        // Load with rd matching rs2 only
        issue(enc(5'd12, 5'd2, 5'd0, 3'd2, 7'd0), alu_ctrl() | 16'h0001, c);
        issue(enc(5'd13, 5'd1, 5'd12, 3'd0, 7'd0), alu_ctrl(), c);
        n_cmp++;
        if (c !== 2) begin
            n_bad++;
            $display("FAIL load_use_rs2: got %0d cycles expected 2", c);
        end
        step();
    endtask

    task automatic test_backpressure();
        int c;
        idle();
        issue(enc(5'd11, 5'd1, 5'd9, 3'd0, 7'd0), alu_ctrl(), c);
        bus.out_ready = 0;
        bus.in_valid  = 1;
        bus.in_instr  = enc(5'd14, 5'd9, 5'd2, 3'd0, 7'd0);
        bus.in_ctrl   = alu_ctrl();
        for (int i = 0; i < 3; i++) begin
            bus.wb_we = (i == 1); bus.wb_addr = 5'd9; bus.wb_data = 32'h0000_BEEF;
            step();
        end
        bus.wb_we = 0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_rs2_data !== 32'hBEEF || bus.out_rd_addr !== 5'd11) begin
            n_bad++;
            $display("FAIL backpressure_hold: got valid=%b rs2=%h rd=%0d expected 1/beef/11",
                     bus.out_valid, bus.out_rs2_data, bus.out_rd_addr);
        end
        bus.out_ready = 1;
        issue(enc(5'd14, 5'd9, 5'd2, 3'd0, 7'd0), alu_ctrl(), c);
        step();
    endtask

    task automatic test_flush();
        int c;
        idle();
        issue(enc(5'd15, 5'd3, 5'd4, 3'd5, 7'd32), alu_ctrl(), c);
        bus.out_ready = 0;
        step();
        bus.flush    = 1;
        bus.in_valid = 1;
        bus.in_instr = enc(5'd16, 5'd1, 5'd1, 3'd0, 7'd0);
        bus.in_ctrl  = alu_ctrl();
        step();
        bus.flush    = 0;
        bus.in_valid = 0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== '0) begin
            n_bad++;
            $display("FAIL flush_kill: got valid=%b ctrl=%h expected 0/0", bus.out_valid, bus.out_ctrl);
        end
        bus.out_ready = 1;
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_no_accept: got valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_perf();
`ifdef DECODE_PERF_EN
        n_cmp++;
        if (bus.stall_cnt !== m_stall[31:0]) begin
            n_bad++;
            $display("FAIL stall_cnt: got %0d expected %0d", bus.stall_cnt, m_stall);
        end
        n_cmp++;
        if (bus.bubble_cnt !== m_bubble[31:0]) begin
            n_bad++;
            $display("FAIL bubble_cnt: got %0d expected %0d", bus.bubble_cnt, m_bubble);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_bypass();
        test_load_use();
        test_backpressure();
        test_flush();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
